miriscv_mem_arbiter: RTL and testbench

- Shares one 64-bit memory port between the MIRISCV core's instruction-fetch port and data port.
- Each core port issues single-cycle request pulses, which the arbiter buffers in a one-entry pending slot.
- Pending slots are arbitrated round-robin onto a req/gnt memory port.
- In-order responses are routed back to the issuing port through a tag FIFO. Data accesses are lane-mapped onto the 64-bit word.

---
 rtl/miriscv_mem_arbiter_if.sv | 51 +++++
 rtl/miriscv_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_mem_arbiter_if.sv
// Bundles the fetch port, data port and shared memory port of the MIRISCV
// memory arbiter; slave is the arbiter's view, master the environment's.
interface miriscv_mem_arbiter_if #(
  parameter int INSTR_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic                     instr_req;
  logic [ADDR_WIDTH-1:0]    instr_addr;
  logic                     instr_rvalid;
  logic [INSTR_WIDTH-1:0]   instr_rdata;

  logic                     data_req;
  logic [ADDR_WIDTH-1:0]    data_addr;
  logic                     data_we;
  logic [DATA_WIDTH/8-1:0]  data_be;
  logic [DATA_WIDTH-1:0]    data_wdata;
  logic                     data_rvalid;
  logic [DATA_WIDTH-1:0]    data_rdata;

  logic                     mem_req;
  logic                     mem_gnt;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic                     mem_we;
  logic [INSTR_WIDTH/8-1:0] mem_be;
  logic [INSTR_WIDTH-1:0]   mem_wdata;
  logic                     mem_rvalid;
  logic [INSTR_WIDTH-1:0]   mem_rdata;

  logic                     err;

  modport slave (
    input  instr_req, instr_addr,
    input  data_req, data_addr, data_we, data_be, data_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output instr_rvalid, instr_rdata,
    output data_rvalid, data_rdata,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output err
  );

  modport master (
    output instr_req, instr_addr,
    output data_req, data_addr, data_we, data_be, data_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  instr_rvalid, instr_rdata,
    input  data_rvalid, data_rdata,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  err
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory port between the MIRISCV
// fetch and data ports; in-order responses are steered back via a tag FIFO.
module miriscv_mem_arbiter #(
  parameter int INSTR_WIDTH     = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  miriscv_mem_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                   instr_valid_q;
  logic [ADDR_WIDTH-1:0]  instr_addr_q;
  logic                   data_valid_q;
  logic [ADDR_WIDTH-1:0]  data_addr_q;
  logic                   data_we_q;
  logic [BE_W-1:0]        data_be_q;
  logic [DATA_WIDTH-1:0]  data_wdata_q;

  logic                   last_data_q;
  logic                   hold_q;
  logic                   hold_data_q;

  logic [1:0]             tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic                   instr_rvalid_q;
  logic [INSTR_WIDTH-1:0] instr_rdata_q;
  logic                   data_rvalid_q;
  logic [DATA_WIDTH-1:0]  data_rdata_q;
  logic                   err_q;

  logic                   sel_data;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   mem_req;
  logic                   xfer;
  logic                   xfer_instr;
  logic                   xfer_data;
  logic                   pop;
  logic                   head_src;
  logic                   head_a2;
  logic                   err_set;

  // A refused offer is locked so a newly arriving request cannot steal the port.
  always_comb begin
    sel_data = data_valid_q;
    if (hold_q) begin
      sel_data = hold_data_q;
    end else if (instr_valid_q && data_valid_q) begin
      sel_data = ~last_data_q;
    end
  end

  assign sel_addr   = sel_data ? data_addr_q : instr_addr_q;
  assign mem_req    = (instr_valid_q | data_valid_q) && (count_q < CNT_W'(MAX_OUTSTANDING));
  assign xfer       = mem_req & bus.mem_gnt;
  assign xfer_instr = xfer & ~sel_data;
  assign xfer_data  = xfer & sel_data;
  assign pop        = bus.mem_rvalid && (count_q != '0);
  assign {head_src, head_a2} = tag_mem[rd_ptr_q];

  assign err_set = (bus.instr_req & instr_valid_q & ~xfer_instr)
                 | (bus.data_req & data_valid_q & ~xfer_data)
                 | (bus.mem_rvalid & (count_q == '0));

  always_comb begin
    count_d = count_q;
    case ({xfer, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Memory fields are forced to zero whenever no request is being offered.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (mem_req) begin
      bus.mem_addr = sel_addr & ~ADDR_WIDTH'(7);
      if (sel_data) begin
        bus.mem_we    = data_we_q;
        bus.mem_be    = data_addr_q[2] ? {data_be_q, {BE_W{1'b0}}} : {{BE_W{1'b0}}, data_be_q};
        bus.mem_wdata = {data_wdata_q, data_wdata_q};
      end else begin
        bus.mem_be = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid_q <= 1'b0;
      instr_addr_q  <= '0;
      data_valid_q  <= 1'b0;
      data_addr_q   <= '0;
      data_we_q     <= 1'b0;
      data_be_q     <= '0;
      data_wdata_q  <= '0;
      last_data_q   <= 1'b0;
      hold_q        <= 1'b0;
      hold_data_q   <= 1'b0;
    end else begin
      if (bus.instr_req && (!instr_valid_q || xfer_instr)) begin
        instr_valid_q <= 1'b1;
        instr_addr_q  <= bus.instr_addr;
      end else if (xfer_instr) begin
        instr_valid_q <= 1'b0;
      end

      if (bus.data_req && (!data_valid_q || xfer_data)) begin
        data_valid_q <= 1'b1;
        data_addr_q  <= bus.data_addr;
        data_we_q    <= bus.data_we;
        data_be_q    <= bus.data_be;
        data_wdata_q <= bus.data_wdata;
      end else if (xfer_data) begin
        data_valid_q <= 1'b0;
      end

      if (xfer) begin
        last_data_q <= sel_data;
        hold_q      <= 1'b0;
      end else if (mem_req) begin
        hold_q      <= 1'b1;
        hold_data_q <= sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      tag_mem[wr_ptr_q] <= {sel_data, sel_addr[2]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      instr_rvalid_q <= 1'b0;
      instr_rdata_q  <= '0;
      data_rvalid_q  <= 1'b0;
      data_rdata_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      if (xfer) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q        <= count_d;
      instr_rvalid_q <= pop & ~head_src;
      data_rvalid_q  <= pop & head_src;
      if (pop && !head_src) begin
        instr_rdata_q <= bus.mem_rdata;
      end
      if (pop && head_src) begin
        data_rdata_q <= head_a2 ? bus.mem_rdata[INSTR_WIDTH-1 -: DATA_WIDTH]
                                : bus.mem_rdata[DATA_WIDTH-1:0];
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.mem_req      = mem_req;
  assign bus.instr_rvalid = instr_rvalid_q;
  assign bus.instr_rdata  = instr_rdata_q;
  assign bus.data_rvalid  = data_rvalid_q;
  assign bus.data_rdata   = data_rdata_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_miriscv_mem_arbiter;
  localparam int IW   = 64;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  miriscv_mem_arbiter_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  miriscv_mem_arbiter #(
    .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic src;   // 0 = instr, 1 = data
    logic a2;
    logic we;
  } tag_t;

  // Model: one pending request per port, queue of granted-but-unanswered tags.
  tag_t        tagq[$];
  logic        mv_i, mv_d;
  logic [31:0] ma_i, ma_d;
  logic        mwe;
  logic [3:0]  mbe;
  logic [31:0] mwd;
  logic        last_granted_data;
  logic        offer_refused;
  logic        refused_port;
  logic        e_irv, e_drv, e_err, e_drd_known;
  logic [63:0] e_irdata;
  logic [31:0] e_drdata;
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_req();
    return (mv_i || mv_d) && (tagq.size() < MAXO);
  endfunction

  function automatic logic model_sel();
    if (offer_refused) return refused_port;
    if (mv_i && mv_d)  return !last_granted_data;
    return mv_d;
  endfunction

  task automatic model_reset();
    tagq.delete();
    mv_i = 0; mv_d = 0; ma_i = 0; ma_d = 0; mwe = 0; mbe = 0; mwd = 0;
    last_granted_data = 0;
    offer_refused = 0; refused_port = 0;
    e_irv = 0; e_drv = 0; e_err = 0; e_drd_known = 1;
    e_irdata = 0; e_drdata = 0;
  endtask

  task automatic model_edge();
    logic        req, s;
    tag_t        h, t;
    logic [63:0] rd;
    req = model_req();
    s   = model_sel();
    rd  = bus.mem_rdata;
    e_irv = 0;
    e_drv = 0;
    if (bus.mem_rvalid) begin
      if (tagq.size() == 0) begin
        e_err = 1;
      end else begin
        h = tagq.pop_front();
        if (!h.src) begin
          e_irv = 1;
          e_irdata = rd;
        end else begin
          e_drv = 1;
          e_drd_known = !h.we;
          e_drdata = h.a2 ? rd[63:32] : rd[31:0];
        end
      end
    end
    if (req && bus.mem_gnt) begin
      t.src = s;
      t.a2  = s ? ma_d[2] : ma_i[2];
      t.we  = s ? mwe : 1'b0;
      tagq.push_back(t);
      if (s) mv_d = 0; else mv_i = 0;
      last_granted_data = s;
      offer_refused = 0;
    end else if (req) begin
      offer_refused = 1;
      refused_port  = s;
    end
    if (bus.instr_req) begin
      if (mv_i) e_err = 1;
      else begin mv_i = 1; ma_i = bus.instr_addr; end
    end
    if (bus.data_req) begin
      if (mv_d) e_err = 1;
      else begin
        mv_d = 1; ma_d = bus.data_addr; mwe = bus.data_we; mbe = bus.data_be; mwd = bus.data_wdata;
      end
    end
  endtask

  task automatic compare_outputs();
    logic        s;
    logic [31:0] a;
    check("mem_req", bus.mem_req, model_req());
    if (model_req()) begin
      s = model_sel();
      a = s ? ma_d : ma_i;
      check("mem_addr", bus.mem_addr, {a[31:3], 3'b000});
      if (s) begin
        check("mem_we", bus.mem_we, mwe);
        check("mem_be", bus.mem_be, a[2] ? {mbe, 4'h0} : {4'h0, mbe});
        check("mem_wdata", bus.mem_wdata, {mwd, mwd});
      end else begin
        check("mem_we", bus.mem_we, 1'b0);
        check("mem_be", bus.mem_be, 8'hFF);
      end
    end
    check("instr_rvalid", bus.instr_rvalid, e_irv);
    check("data_rvalid", bus.data_rvalid, e_drv);
    check("instr_rdata", bus.instr_rdata, e_irdata);
    if (e_drd_known) check("data_rdata", bus.data_rdata, e_drdata);
    check("rvalid_excl", bus.instr_rvalid & bus.data_rvalid, 1'b0);
    check("err", bus.err, e_err);
  endtask

  always @(negedge clk) begin
    if (chk_en) compare_outputs();
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    bus.instr_req  = 0;
    bus.data_req   = 0;
    bus.mem_rvalid = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.instr_req  = 1;
    bus.instr_addr = a;
  endtask

  task automatic dreq(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    bus.data_req   = 1;
    bus.data_addr  = a;
    bus.data_we    = we;
    bus.data_be    = be;
    bus.data_wdata = wd;
  endtask

  task automatic respond(input logic [63:0] d);
    bus.mem_rvalid = 1;
    bus.mem_rdata  = d;
    step();
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    model_reset();
    chk_en = 1;
    #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_instr_rvalid", bus.instr_rvalid, 0);
    check("rst_instr_rdata", bus.instr_rdata, 0);
    check("rst_data_rvalid", bus.data_rvalid, 0);
    check("rst_data_rdata", bus.data_rdata, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.instr_req = 0; bus.instr_addr = 0;
    bus.data_req = 0; bus.data_addr = 0; bus.data_we = 0; bus.data_be = 0; bus.data_wdata = 0;
    bus.mem_gnt = 1; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    #1;
    do_reset();

    // Single fetch
    fetch(32'h104); step();
    check("fetch_req", bus.mem_req, 1);
    check("fetch_addr", bus.mem_addr, 32'h100);
    check("fetch_be", bus.mem_be, 8'hFF);
    check("fetch_we", bus.mem_we, 0);
    step(); step();
    respond(64'hDEADBEEF_01234567);
    check("fetch_rvalid", bus.instr_rvalid, 1);
    check("fetch_rdata", bus.instr_rdata, 64'hDEADBEEF_01234567);
    check("fetch_no_drvalid", bus.data_rvalid, 0);
    step();
    check("fetch_rvalid_pulse", bus.instr_rvalid, 0);
    check("fetch_rdata_hold", bus.instr_rdata, 64'hDEADBEEF_01234567);

    // Conflict: data first after reset
    fetch(32'h200); dreq(32'h304, 0, 4'hF, 0); step();
    check("conf1_first", bus.mem_addr, 32'h300);
    step();
    check("conf1_second", bus.mem_addr, 32'h200);
    step();
    respond(64'h11112222_33334444);
    check("conf1_resp_data", bus.data_rvalid, 1);
    check("conf1_rdata_hi", bus.data_rdata, 32'h11112222);
    respond(64'hAAAA5555_CCCC9999);
    check("conf1_resp_instr", bus.instr_rvalid, 1);
    check("conf1_irdata", bus.instr_rdata, 64'hAAAA5555_CCCC9999);
    // Lone data grant moves the pointer to data, so the next conflict goes to instr
    dreq(32'h10, 0, 4'hF, 0); step(); step();
    respond(64'h0);
    fetch(32'h400); dreq(32'h500, 0, 4'hF, 0); step();
    check("conf2_first", bus.mem_addr, 32'h400);
    step();
    check("conf2_second", bus.mem_addr, 32'h500);
    step();
    respond(64'h01020304_05060708);
    check("conf2_resp_instr", bus.instr_rvalid, 1);
    respond(64'h0A0B0C0D_0E0F1011);
    check("conf2_resp_data", bus.data_rvalid, 1);
    check("conf2_rdata_lo", bus.data_rdata, 32'h0E0F1011);

    // Store lane mapping, then load from the lower lane
    dreq(32'h2C, 1, 4'h3, 32'hAABBCCDD); step();
    check("st_addr", bus.mem_addr, 32'h28);
    check("st_be", bus.mem_be, 8'h30);
    check("st_wdata", bus.mem_wdata, 64'hAABBCCDD_AABBCCDD);
    check("st_we", bus.mem_we, 1);
    step();
    respond(64'h0);
    check("st_rvalid", bus.data_rvalid, 1);
    dreq(32'h28, 0, 4'hF, 0); step(); step();
    respond(64'h11112222_33334444);
    check("ld_rdata", bus.data_rdata, 32'h33334444);

    // Backpressure
    bus.mem_gnt = 0;
    fetch(32'h80C); step();
    for (int i = 0; i < 5; i++) begin
      check("bp_req", bus.mem_req, 1);
      check("bp_addr", bus.mem_addr, 32'h808);
      if (i == 2) fetch(32'h900);
      step();
    end
    check("bp_err", bus.err, 1);
    bus.mem_gnt = 1;
    step();
    check("bp_one_xfer", bus.mem_req, 0);
    step();
    check("bp_dropped", bus.mem_req, 0);
    respond(64'h5555AAAA_5555AAAA);
    check("bp_rvalid", bus.instr_rvalid, 1);

    // Outstanding limit and spurious response
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(32'h1000 + 32'(i * 8)); step();
    end
    check("lim_req_low", bus.mem_req, 0);
    step();
    check("lim_req_still_low", bus.mem_req, 0);
    respond(64'h1);
    check("lim_req_back", bus.mem_req, 1);
    step();
    for (int i = 0; i < 4; i++) respond(64'(i + 2));
    check("lim_err_clear", bus.err, 0);
    respond(64'hFFFF);
    check("spurious_err", bus.err, 1);

    // Reset with two outstanding and one pending
    do_reset();
    fetch(32'h2000); step();
    fetch(32'h2008); step();
    fetch(32'h2010); step();
    bus.mem_gnt = 0;
    check("pre_rst_req", bus.mem_req, 1);
    do_reset();
    bus.mem_gnt = 1;
    fetch(32'h3004); step();
    check("post_rst_addr", bus.mem_addr, 32'h3000);
    step(); step();
    respond(64'hCAFEF00D_12345678);
    check("post_rst_rvalid", bus.instr_rvalid, 1);
    check("post_rst_rdata", bus.instr_rdata, 64'hCAFEF00D_12345678);
    check("post_rst_err", bus.err, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.mem_gnt = ($urandom_range(0, 9) < 7);
      if ((!mv_i || $urandom_range(0, 49) == 0) && $urandom_range(0, 9) < 3)
        fetch($urandom);
      if ((!mv_d || $urandom_range(0, 49) == 0) && $urandom_range(0, 9) < 3)
        dreq($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      if (tagq.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.mem_rvalid = 1;
        bus.mem_rdata  = {$urandom, $urandom};
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
